// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Pipeline stage that sits directly after execute. Memory instructions go out
// on the data bus with a valid / data_ok handshake. Load data is aligned and
// extended, and store byte strobes are generated here. The stage stalls the
// pipeline while a bus access is outstanding. All other instructions pass
// through in the same cycle.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset
//   dataE   in   exec_data_t : address = aluout, store data = rd, ctl.op
//   flush   in   kill the instruction currently held in this stage
//   dresp   in   dbus_resp_t : data_ok strobe and 64-bit read data
//   dreq    out  dbus_req_t  : valid, addr, size, strobe, data
//   dataM   out  mem_data_t  : result and pass-through fields for writeback
//   stallM  out  high while a memory access is outstanding; upstream holds
//                dataE stable while this is high
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   When defined, misaligned H/W/D accesses do not reach the bus. Instead they
//   raise an exception in the same cycle: cause 4 for loads, 6 for stores, and
//   tval set to the address. When undefined, misaligned accesses are issued
//   unchanged, and the strobe is cut off at the 8-byte boundary.
// ---------------------------------------------------------------------------

package memory_stage_pkg;

   typedef enum logic [4:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_LUI,
      OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
      OP_SB, OP_SH, OP_SW, OP_SD
   } decoded_op_t;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      decoded_op_t op;
      logic        regwrite;
   } control_t;

   typedef struct packed {
      logic        valid;
      control_t    ctl;
      logic [4:0]  dst;
      logic [31:0] instr;
      logic [63:0] aluout;
      logic [63:0] rd;
      logic [11:0] csr_addr;
      logic [63:0] csr_data;
   } exec_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      control_t    ctl;
      logic [4:0]  dst;
      logic [31:0] instr;
      logic [63:0] result;
      logic [11:0] csr_addr;
      logic [63:0] csr_data;
`ifdef MEM_MISALIGN_CHECK_EN
      logic        exc_valid;
      logic [3:0]  exc_cause;
      logic [63:0] exc_tval;
`endif
   } mem_data_t;

endpackage

module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  exec_data_t dataE,
   input  logic       flush,
   input  dbus_resp_t dresp,
   output dbus_req_t  dreq,
   output mem_data_t  dataM,
   output logic       stallM
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            killed_q, killed_d;
   logic [XLEN-1:0] result_q, result_d;

   // ------------------------------------------------------------------
   // Decode of the memory operation
   // ------------------------------------------------------------------
   logic   is_load;
   logic   is_store;
   logic   is_mem;
   logic   ld_signed;
   msize_t msize;

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      ld_signed = 1'b0;
      msize     = MSIZE1;
      case (dataE.ctl.op)
         OP_LB:   begin is_load = 1'b1; ld_signed = 1'b1; msize = MSIZE1; end
         OP_LH:   begin is_load = 1'b1; ld_signed = 1'b1; msize = MSIZE2; end
         OP_LW:   begin is_load = 1'b1; ld_signed = 1'b1; msize = MSIZE4; end
         OP_LD:   begin is_load = 1'b1;                   msize = MSIZE8; end
         OP_LBU:  begin is_load = 1'b1;                   msize = MSIZE1; end
         OP_LHU:  begin is_load = 1'b1;                   msize = MSIZE2; end
         OP_LWU:  begin is_load = 1'b1;                   msize = MSIZE4; end
         OP_SB:   begin is_store = 1'b1;                  msize = MSIZE1; end
         OP_SH:   begin is_store = 1'b1;                  msize = MSIZE2; end
         OP_SW:   begin is_store = 1'b1;                  msize = MSIZE4; end
         OP_SD:   begin is_store = 1'b1;                  msize = MSIZE8; end
         default: ;
      endcase
   end

   assign is_mem = is_load | is_store;

   // ------------------------------------------------------------------
   // Byte lane placement for stores, alignment/extension for loads
   // ------------------------------------------------------------------
   logic [2:0]      byte_off;
   logic [5:0]      bit_off;
   logic [7:0]      base_strobe;
   logic [7:0]      store_strobe;
   logic [XLEN-1:0] store_data;
   logic [XLEN-1:0] load_raw;
   logic [XLEN-1:0] load_value;
   logic [XLEN-1:0] access_value;

   assign byte_off = dataE.aluout[2:0];
   assign bit_off  = {byte_off, 3'b000};

   always_comb begin
      base_strobe = 8'h01;
      case (msize)
         MSIZE1: base_strobe = 8'h01;
         MSIZE2: base_strobe = 8'h03;
         MSIZE4: base_strobe = 8'h0F;
         MSIZE8: base_strobe = 8'hFF;
      endcase
   end

   // The 8-bit shift drops lanes past byte 7, so a misaligned access that is
   // issued unchanged loses its upper bytes instead of wrapping around.
   assign store_strobe = base_strobe << byte_off;
   assign store_data   = dataE.rd << bit_off;
   assign load_raw     = dresp.data >> bit_off;

   always_comb begin
      load_value = load_raw;
      case (msize)
         MSIZE1: load_value = ld_signed ? {{(XLEN-8){load_raw[7]}},   load_raw[7:0]}
                                        : {{(XLEN-8){1'b0}},          load_raw[7:0]};
         MSIZE2: load_value = ld_signed ? {{(XLEN-16){load_raw[15]}}, load_raw[15:0]}
                                        : {{(XLEN-16){1'b0}},         load_raw[15:0]};
         MSIZE4: load_value = ld_signed ? {{(XLEN-32){load_raw[31]}}, load_raw[31:0]}
                                        : {{(XLEN-32){1'b0}},         load_raw[31:0]};
         MSIZE8: load_value = load_raw;
      endcase
   end

   // Stores write back nothing, so their result is forced to zero.
   assign access_value = is_load ? load_value : '0;

`ifdef MEM_MISALIGN_CHECK_EN
   logic misaligned;

   always_comb begin
      misaligned = 1'b0;
      case (msize)
         MSIZE1: misaligned = 1'b0;
         MSIZE2: misaligned = dataE.aluout[0];
         MSIZE4: misaligned = |dataE.aluout[1:0];
         MSIZE8: misaligned = |dataE.aluout[2:0];
      endcase
   end
`endif

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   logic            req_valid;
   logic            stall;
   logic            out_valid;
   logic [XLEN-1:0] out_result;
`ifdef MEM_MISALIGN_CHECK_EN
   logic            out_exc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         killed_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         killed_q <= killed_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      killed_d   = killed_q;
      result_d   = result_q;
      req_valid  = 1'b0;
      stall      = 1'b0;
      out_valid  = 1'b0;
      out_result = '0;
`ifdef MEM_MISALIGN_CHECK_EN
      out_exc    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (dataE.valid && !flush) begin
               if (!is_mem) begin
                  out_valid  = 1'b1;
                  out_result = dataE.aluout;
               end
`ifdef MEM_MISALIGN_CHECK_EN
               else if (misaligned) begin
                  out_valid = 1'b1;
                  out_exc   = 1'b1;
               end
`endif
               else begin
                  req_valid = 1'b1;
                  stall     = 1'b1;
                  // A zero-wait response skips WAIT.
                  if (dresp.data_ok) begin
                     result_d = access_value;
                     state_d  = S_DONE;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
         end

         S_WAIT: begin
            // The bus cannot be cancelled, so the request stays up even
            // after a flush.
            req_valid = 1'b1;
            stall     = 1'b1;
            if (flush) begin
               killed_d = 1'b1;
            end
            if (dresp.data_ok) begin
               if (killed_q || flush) begin
                  // Release the stall so that the dead instruction leaves
                  // the upstream register. It is then never reissued.
                  stall    = 1'b0;
                  killed_d = 1'b0;
                  state_d  = S_IDLE;
               end else begin
                  result_d = access_value;
                  state_d  = S_DONE;
               end
            end
         end

         S_DONE: begin
            // dataE still holds the finished instruction. It advances this
            // cycle. A flush arriving now still suppresses the writeback.
            out_valid  = !flush;
            out_result = result_q;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output assembly. Every field is zero when it is not meaningful and
   // for the whole reset cycle.
   // ------------------------------------------------------------------
   always_comb begin
      dreq   = '0;
      dataM  = '0;
      stallM = 1'b0;
      if (!reset) begin
         stallM = stall;
         if (req_valid) begin
            dreq.valid = 1'b1;
            dreq.addr  = dataE.aluout;
            dreq.size  = msize;
            if (is_store) begin
               dreq.strobe = store_strobe;
               dreq.data   = store_data;
            end
         end
         if (out_valid) begin
            dataM.valid    = 1'b1;
            dataM.ctl      = dataE.ctl;
            dataM.dst      = dataE.dst;
            dataM.instr    = dataE.instr;
            dataM.result   = out_result;
            dataM.csr_addr = dataE.csr_addr;
            dataM.csr_data = dataE.csr_data;
`ifdef MEM_MISALIGN_CHECK_EN
            if (out_exc) begin
               dataM.exc_valid = 1'b1;
               dataM.exc_cause = is_load ? 4'd4 : 4'd6;
               dataM.exc_tval  = dataE.aluout;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//
// Self-checking bench for memory_stage. A transaction-level model predicts
// dreq, dataM and stallM on every cycle. Byte-lane loops build the expected
// strobes and data, and plain arithmetic performs sign/zero extension. A
// directed section pins the model with hand-computed literals. After it comes
// a randomized section, in which the bench plays the upstream stage (holding
// dataE while the model says the stage is stalled) and also plays the bus
// responder.
// ---------------------------------------------------------------------------
module tb_memory_stage;
   import memory_stage_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   exec_data_t dataE;
   logic       flush;
   dbus_resp_t dresp;
   dbus_req_t  dreq;
   mem_data_t  dataM;
   logic       stallM;

   always #5 clk = ~clk;

   memory_stage #(.XLEN(64)) dut (
      .clk    (clk),
      .reset  (reset),
      .dataE  (dataE),
      .flush  (flush),
      .dresp  (dresp),
      .dreq   (dreq),
      .dataM  (dataM),
      .stallM (stallM)
   );

   int n_vec = 0;
   int n_bad = 0;

   // model state: request outstanding, killed, result due this cycle
   bit          m_busy;
   bit          m_killed;
   bit          m_deliver;
   logic [63:0] m_val;

   dbus_req_t   e_req;
   mem_data_t   e_out;
   logic        e_stall;

   decoded_op_t op_tab [15] = '{OP_ADD, OP_SUB, OP_XOR, OP_NOP,
                                OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
                                OP_SB, OP_SH, OP_SW, OP_SD};

   function automatic int nbytes(decoded_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_LWU, OP_SW: return 4;
         OP_LD, OP_SD:         return 8;
         default:              return 0;
      endcase
   endfunction

   function automatic bit is_ld(decoded_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
   endfunction

   function automatic bit is_st(decoded_op_t op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
   endfunction

   function automatic msize_t size_of(decoded_op_t op);
      case (nbytes(op))
         2:       return MSIZE2;
         4:       return MSIZE4;
         8:       return MSIZE8;
         default: return MSIZE1;
      endcase
   endfunction

`ifdef MEM_MISALIGN_CHECK_EN
   function automatic bit misal(decoded_op_t op, logic [63:0] a);
      int off;
      off = int'(a[2:0]);
      return (off % nbytes(op)) != 0;
   endfunction
`endif

   // Value that a completed access writes back.
   function automatic logic [63:0] access_value(decoded_op_t op, logic [63:0] a, logic [63:0] bus);
      logic [63:0] v;
      int off, n;
      v   = '0;
      off = int'(a[2:0]);
      n   = nbytes(op);
      if (!is_ld(op)) return '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) v[8*i +: 8] = bus[8*(off+i) +: 8];
      if ((op == OP_LB || op == OP_LH || op == OP_LW) && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic dbus_req_t bus_req(exec_data_t d);
      dbus_req_t r;
      int off, n;
      r       = '0;
      off     = int'(d.aluout[2:0]);
      n       = nbytes(d.ctl.op);
      r.valid = 1'b1;
      r.addr  = d.aluout;
      r.size  = size_of(d.ctl.op);
      if (is_st(d.ctl.op)) begin
         for (int i = 0; i < 8; i++) begin
            if (i >= off && i < off + n) r.strobe[i] = 1'b1;
            if (i >= off) r.data[8*i +: 8] = d.rd[8*(i-off) +: 8];
         end
      end
      return r;
   endfunction

   function automatic mem_data_t pass(exec_data_t d, logic [63:0] res);
      mem_data_t m;
      m          = '0;
      m.valid    = 1'b1;
      m.ctl      = d.ctl;
      m.dst      = d.dst;
      m.instr    = d.instr;
      m.result   = res;
      m.csr_addr = d.csr_addr;
      m.csr_data = d.csr_data;
      return m;
   endfunction

   function automatic exec_data_t mk(decoded_op_t op, logic [63:0] a, logic [63:0] rdv);
      exec_data_t d;
      d.valid        = 1'b1;
      d.ctl.op       = op;
      d.ctl.regwrite = !is_st(op);
      d.dst          = 5'($urandom);
      d.instr        = $urandom;
      d.aluout       = a;
      d.rd           = rdv;
      d.csr_addr     = 12'($urandom);
      d.csr_data     = {$urandom, $urandom};
      return d;
   endfunction

   // True when the model expects a bus request this cycle.
   function automatic bit req_expected();
      if (reset || m_deliver) return 1'b0;
      if (m_busy) return 1'b1;
      if (!dataE.valid || flush || !(is_ld(dataE.ctl.op) || is_st(dataE.ctl.op))) return 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      if (misal(dataE.ctl.op, dataE.aluout)) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Settle, predict this cycle's outputs, compare, advance the model.
   task automatic eval();
      #1;
      e_req   = '0;
      e_out   = '0;
      e_stall = 1'b0;
      if (reset) begin
         m_busy = 0; m_killed = 0; m_deliver = 0; m_val = '0;
      end else if (m_deliver) begin
         if (!flush) e_out = pass(dataE, m_val);
         m_deliver = 0;
      end else if (m_busy) begin
         e_req = bus_req(dataE);
         if (dresp.data_ok) begin
            m_busy = 0;
            if (m_killed || flush) begin
               m_killed = 0;
            end else begin
               m_deliver = 1;
               m_val     = access_value(dataE.ctl.op, dataE.aluout, dresp.data);
               e_stall   = 1'b1;
            end
         end else begin
            e_stall = 1'b1;
            if (flush) m_killed = 1;
         end
      end else if (dataE.valid && !flush) begin
         if (!(is_ld(dataE.ctl.op) || is_st(dataE.ctl.op))) begin
            e_out = pass(dataE, dataE.aluout);
         end
`ifdef MEM_MISALIGN_CHECK_EN
         else if (misal(dataE.ctl.op, dataE.aluout)) begin
            e_out           = pass(dataE, 64'd0);
            e_out.exc_valid = 1'b1;
            e_out.exc_cause = is_ld(dataE.ctl.op) ? 4'd4 : 4'd6;
            e_out.exc_tval  = dataE.aluout;
         end
`endif
         else begin
            e_req   = bus_req(dataE);
            e_stall = 1'b1;
            if (dresp.data_ok) begin
               m_deliver = 1;
               m_val     = access_value(dataE.ctl.op, dataE.aluout, dresp.data);
            end else begin
               m_busy = 1;
            end
         end
      end
      chk("dreq",   256'(dreq),   256'(e_req));
      chk("dataM",  256'(dataM),  256'(e_out));
      chk("stallM", 256'(stallM), 256'(e_stall));
      if (e_out.valid)
         $display("[%0t] op=%0d addr=%h result=%h", $time, dataE.ctl.op, dataE.aluout, e_out.result);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit advance;
      m_busy = 0; m_killed = 0; m_deliver = 0; m_val = '0;
      reset = 1'b1; dataE = '0; flush = 1'b0; dresp = '0;
      tick();
      eval();
      chk("rst_stall", 256'(stallM), 256'(1'b0));
      tick();
      reset = 1'b0;

      // LD, data_ok on the third stall cycle
      dataE = mk(OP_LD, 64'h80001000, 64'h0);
      eval(); chk("ld_stall0", 256'(stallM), 256'(1'b1)); chk("ld_size", 256'(dreq.size), 256'(MSIZE8)); tick();
      eval(); chk("ld_stall1", 256'(stallM), 256'(1'b1)); tick();
      dresp.data_ok = 1'b1; dresp.data = 64'h1122334455667788;
      eval(); chk("ld_stall2", 256'(stallM), 256'(1'b1)); tick();
      dresp = '0;
      eval(); chk("ld_valid", 256'(dataM.valid), 256'(1'b1));
      chk("ld_result", 256'(dataM.result), 256'(64'h1122334455667788)); tick();

      // ADD passes straight through
      dataE = mk(OP_ADD, 64'd5, 64'd0);
      eval(); chk("add_result", 256'(dataM.result), 256'(64'd5));
      chk("add_noreq", 256'(dreq.valid), 256'(1'b0)); tick();

      // LB / LBU with a zero-wait response
      dataE = mk(OP_LB, 64'h80001003, 64'd0);
      dresp.data_ok = 1'b1; dresp.data = 64'h00000000F0000000;
      eval(); tick();
      dresp = '0;
      eval(); chk("lb_result", 256'(dataM.result), 256'(64'hFFFFFFFFFFFFFFF0)); tick();
      dataE = mk(OP_LBU, 64'h80001003, 64'd0);
      dresp.data_ok = 1'b1; dresp.data = 64'h00000000F0000000;
      eval(); tick();
      dresp = '0;
      eval(); chk("lbu_result", 256'(dataM.result), 256'(64'h00000000000000F0)); tick();

      // SH at byte 6
      dataE = mk(OP_SH, 64'h80002006, 64'hABCD);
      eval(); chk("sh_strobe", 256'(dreq.strobe), 256'(8'hC0));
      chk("sh_data", 256'(dreq.data), 256'(64'hABCD000000000000));
      chk("sh_size", 256'(dreq.size), 256'(MSIZE2)); tick();
      dresp.data_ok = 1'b1; eval(); tick();
      dresp = '0;
      eval(); chk("sh_valid", 256'(dataM.valid), 256'(1'b1)); tick();

      // LW killed while waiting
      dataE = mk(OP_LW, 64'h80003004, 64'd0);
      eval(); tick();
      flush = 1'b1; eval(); chk("kill_req0", 256'(dreq.valid), 256'(1'b1)); tick();
      flush = 1'b0; eval(); chk("kill_req1", 256'(dreq.valid), 256'(1'b1)); tick();
      dresp.data_ok = 1'b1; dresp.data = 64'h12345678;
      eval(); chk("kill_req2", 256'(dreq.valid), 256'(1'b1));
      chk("kill_nov", 256'(dataM.valid), 256'(1'b0)); tick();
      dresp = '0; dataE = '0;
      eval(); chk("kill_idle", 256'(dataM.valid), 256'(1'b0));
      chk("kill_noreq", 256'(dreq.valid), 256'(1'b0)); tick();

      // reset while waiting
      dataE = mk(OP_LD, 64'h80004000, 64'd0);
      eval(); tick();
      eval(); tick();
      reset = 1'b1;
      eval(); chk("rst_req", 256'(dreq.valid), 256'(1'b0)); chk("rst_stall2", 256'(stallM), 256'(1'b0)); tick();
      reset = 1'b0; dataE = '0;
      eval(); chk("rst_idle", 256'(dreq.valid), 256'(1'b0)); tick();

`ifdef MEM_MISALIGN_CHECK_EN
      dataE = mk(OP_LW, 64'h80000002, 64'd0);
      eval(); chk("mis_req", 256'(dreq.valid), 256'(1'b0));
      chk("mis_cause", 256'(dataM.exc_cause), 256'(4'd4));
      chk("mis_tval", 256'(dataM.exc_tval), 256'(64'h80000002)); tick();
`endif

      // randomized traffic
      advance = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if (advance) begin
            dataE = mk(op_tab[$urandom_range(0, 14)],
                       64'h80000000 + 64'($urandom_range(0, 255)),
                       {$urandom, $urandom});
            if (!is_ld(dataE.ctl.op) && !is_st(dataE.ctl.op)) dataE.aluout = {$urandom, $urandom};
            dataE.valid = ($urandom_range(0, 9) != 0);
         end
         flush = ($urandom_range(0, 9) == 0);
         dresp.data    = {$urandom, $urandom};
         dresp.data_ok = req_expected() && ($urandom_range(0, 2) == 0);
         eval();
         advance = !e_stall;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
